// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution loop-nest sequencer.
// Holds the FSM state enum, lane tiling step, default widths and stride decode.
package conv_pkg;

  localparam int LANES_DEF = 4;
  localparam int DEF_X_W   = 8;
  localparam int DEF_Y_W   = 8;
  localparam int DEF_N_W   = 8;
  localparam int DEF_I_W   = 8;
  localparam int DEF_K_W   = 4;
  localparam int DEF_B_W   = 4;
  localparam int DEF_WEI_AW = 10;
  localparam int DEF_ACT_AW = 10;
  localparam int DEF_PES    = 16;

  localparam logic [2:0] STRIDE_1 = 3'd1;
  localparam logic [2:0] STRIDE_2 = 3'd2;
  localparam logic [2:0] STRIDE_4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    FIN
  } state_t;

  function automatic logic stride_ok(input logic [2:0] s);
    return (s == STRIDE_1) || (s == STRIDE_2) || (s == STRIDE_4);
  endfunction

  function automatic logic [1:0] stride_shift(input logic [2:0] s);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      (s == STRIDE_2): r = 2'd1;
      (s == STRIDE_4): r = 2'd2;
      default:         r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Wrap counter: adds STEP on inc, wraps to 0 when cnt+STEP >= bound.
// Ports: clk, rst, clr (sync clear), inc (carry-in), bound, cnt, co (carry-out).
module conv_loop_counter #(
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] bound,
  output logic [W-1:0] cnt,
  output logic         co
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   nxt;
  logic         wrap;

  assign nxt  = {1'b0, cnt_q} + (W+1)'(STEP);
  assign wrap = nxt >= {1'b0, bound};
  assign co   = inc & wrap;
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = wrap ? '0 : nxt[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop-nest sequencer: start/done engine issuing weight and
// activation buffer reads, pad flag and accumulation markers per beat.
// Ports: config inputs latched on start, out_valid/out_ready beat handshake,
// read enables/addresses, act_pad, pe_valid, first/last_acc, busy, done, cfg_err.
module conv_loop_ctrl
  import conv_pkg::*;
#(
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int N_W    = DEF_N_W,
  parameter int I_W    = DEF_I_W,
  parameter int K_W    = DEF_K_W,
  parameter int B_W    = DEF_B_W,
  parameter int LANES  = LANES_DEF,
  parameter int WEI_AW = DEF_WEI_AW,
  parameter int ACT_AW = DEF_ACT_AW,
  parameter int PES    = DEF_PES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        stride,
  input  logic [K_W-1:0]    fkx,
  input  logic [K_W-1:0]    fky,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [N_W-1:0]    nc,
  input  logic [I_W-1:0]    ic,
  input  logic [B_W-1:0]    batch,
  input  logic [X_W-1:0]    padding_x,
  input  logic [Y_W-1:0]    padding_y,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              wei_read_en,
  output logic              act_read_en,
  output logic [WEI_AW-1:0] wei_read_addr,
  output logic [ACT_AW-1:0] act_read_addr,
  output logic              act_pad,
  output logic [PES-1:0]    pe_valid,
  output logic              first_acc,
  output logic              last_acc,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int LG = $clog2(LANES);
  localparam int XC = X_W + 2;
  localparam int YC = Y_W + 2;

  state_t         state_q, state_d;
  logic [2:0]     stride_q, stride_d;
  logic [K_W-1:0] fkx_q, fkx_d, fky_q, fky_d;
  logic [X_W-1:0] x_q, x_d, px_q, px_d;
  logic [Y_W-1:0] y_q, y_d, py_q, py_d;
  logic [N_W-1:0] nc_q, nc_d;
  logic [I_W-1:0] ic_q, ic_d;
  logic [B_W-1:0] batch_q, batch_d;
  logic [XC-1:0]  ox_q, ox_d;
  logic [YC-1:0]  oy_q, oy_d;
  logic           cfg_err_q, cfg_err_d;

  logic [XC-1:0]  span_x;
  logic [YC-1:0]  span_y;
  logic           run, fire, clr;

  logic [YC-1:0]  yy;
  logic [XC-1:0]  xx;
  logic [K_W-1:0] kkx, kky;
  logic [I_W-1:0] ii;
  logic [N_W-1:0] nn;
  logic [B_W-1:0] bb;
  logic c_yy, c_xx, c_kx, c_ky, c_ii, c_nn, c_bb;

  assign span_x = XC'(x_q) + (XC'(px_q) << 1);
  assign span_y = YC'(y_q) + (YC'(py_q) << 1);

  assign run  = (state_q == RUN);
  assign fire = run & out_ready;
  assign clr  = ~run;

  always_comb begin
    state_d   = state_q;
    stride_d  = stride_q;
    fkx_d     = fkx_q;
    fky_d     = fky_q;
    x_d       = x_q;
    y_d       = y_q;
    px_d      = px_q;
    py_d      = py_q;
    nc_d      = nc_q;
    ic_d      = ic_q;
    batch_d   = batch_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d   = SETUP;
        cfg_err_d = 1'b0;
        stride_d  = stride;
        fkx_d     = fkx;
        fky_d     = fky;
        x_d       = x;
        y_d       = y;
        px_d      = padding_x;
        py_d      = padding_y;
        nc_d      = nc;
        ic_d      = ic;
        batch_d   = batch;
      end
      SETUP: begin
        ox_d = ((span_x - XC'(fkx_q)) >> stride_shift(stride_q)) + XC'(1);
        oy_d = ((span_y - YC'(fky_q)) >> stride_shift(stride_q)) + YC'(1);
        if (!stride_ok(stride_q)) begin
          cfg_err_d = 1'b1;
          state_d   = FIN;
        end else if (batch_q == '0 || nc_q == '0 || ic_q == '0 ||
                     fkx_q == '0 || fky_q == '0) begin
          state_d = FIN;
        end else if (span_x < XC'(fkx_q) || span_y < YC'(fky_q)) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      RUN:  if (c_bb) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stride_q  <= '0;
      fkx_q     <= '0;
      fky_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      px_q      <= '0;
      py_q      <= '0;
      nc_q      <= '0;
      ic_q      <= '0;
      batch_q   <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stride_q  <= stride_d;
      fkx_q     <= fkx_d;
      fky_q     <= fky_d;
      x_q       <= x_d;
      y_q       <= y_d;
      px_q      <= px_d;
      py_q      <= py_d;
      nc_q      <= nc_d;
      ic_q      <= ic_d;
      batch_q   <= batch_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Carry chain, innermost (yy) first.
  conv_loop_counter #(.W(YC), .STEP(1)) u_yy (
    .clk(clk), .rst(rst), .clr(clr), .inc(fire),
    .bound(oy_q), .cnt(yy), .co(c_yy));
  conv_loop_counter #(.W(XC), .STEP(1)) u_xx (
    .clk(clk), .rst(rst), .clr(clr), .inc(c_yy),
    .bound(ox_q), .cnt(xx), .co(c_xx));
  conv_loop_counter #(.W(K_W), .STEP(1)) u_kx (
    .clk(clk), .rst(rst), .clr(clr), .inc(c_xx),
    .bound(fkx_q), .cnt(kkx), .co(c_kx));
  conv_loop_counter #(.W(K_W), .STEP(1)) u_ky (
    .clk(clk), .rst(rst), .clr(clr), .inc(c_kx),
    .bound(fky_q), .cnt(kky), .co(c_ky));
  conv_loop_counter #(.W(I_W), .STEP(LANES)) u_ii (
    .clk(clk), .rst(rst), .clr(clr), .inc(c_ky),
    .bound(ic_q), .cnt(ii), .co(c_ii));
  conv_loop_counter #(.W(N_W), .STEP(LANES)) u_nn (
    .clk(clk), .rst(rst), .clr(clr), .inc(c_ii),
    .bound(nc_q), .cnt(nn), .co(c_nn));
  conv_loop_counter #(.W(B_W), .STEP(1)) u_bb (
    .clk(clk), .rst(rst), .clr(clr), .inc(c_nn),
    .bound(batch_q), .cnt(bb), .co(c_bb));

  logic [31:0]        n4, i4, ic4;
  logic signed [31:0] ix, iy;
  logic               pad_raw;

  assign n4  = 32'(nn) >> LG;
  assign i4  = 32'(ii) >> LG;
  assign ic4 = (32'(ic_q) + 32'(LANES - 1)) >> LG;

  assign ix = $signed(32'(xx) * 32'(stride_q) + 32'(kkx)) - $signed(32'(px_q));
  assign iy = $signed(32'(yy) * 32'(stride_q) + 32'(kky)) - $signed(32'(py_q));

  assign pad_raw = (ix < 0) | (ix >= $signed(32'(x_q))) |
                   (iy < 0) | (iy >= $signed(32'(y_q)));

  // Beat fields are gated so every output is 0 outside RUN.
  assign out_valid   = run;
  assign wei_read_en = run;
  assign act_pad     = run & pad_raw;
  assign act_read_en = run & ~pad_raw;
  assign pe_valid    = {PES{run}};

  assign wei_read_addr = run ? WEI_AW'(
    ((n4 * ic4 + i4) * 32'(fky_q) + 32'(kky)) * 32'(fkx_q) + 32'(kkx)) : '0;

  assign act_read_addr = (run & ~pad_raw) ? ACT_AW'(
    ((32'(bb) * ic4 + i4) * 32'(x_q) + 32'(ix)) * 32'(y_q) + 32'(iy)) : '0;

  assign first_acc = run & (ii == '0) & (kky == '0) & (kkx == '0);
  assign last_acc  = run &
    (({1'b0, ii} + (I_W+1)'(LANES)) >= {1'b0, ic_q}) &
    (kky == fky_q - K_W'(1)) & (kkx == fkx_q - K_W'(1));

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/conv_loop_ctrl.md
Name: conv_loop_ctrl

Overview:
- Hardware loop-nest sequencer for convolution tiles; directly upstream of WEI_BUF, ACT_BUF and PE_ARRAY.
- Walks batch/output-channel/input-channel/kernel/output-pixel loops, with 4-lane channel tiling on nn and ii.
- Issues one weight-buffer read address and one activation-buffer read address per beat, plus pe_valid and accumulation markers for ACCUM.
- Replaces software-driven address sequencing with a start/done-controlled engine.

Parameters:
- X_W, 8, width of x, padding_x and output-x counters.
- Y_W, 8, width of y, padding_y and output-y counters.
- N_W, 8, width of nc.
- I_W, 8, width of ic.
- K_W, 4, width of fkx and fky.
- B_W, 4, width of batch.
- LANES, 4, channel tile step on nn and ii; must be a power of 2.
- WEI_AW, 10, weight buffer address width.
- ACT_AW, 10, activation buffer address width.
- PES, 16, PE count; width of pe_valid.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; latches config and begins the run; ignored unless IDLE.
- stride  in  3  legal values 1, 2, 4.
- fkx, fky  in  K_W  kernel width/height.
- x, y  in  X_W/Y_W  input extents.
- nc  in  N_W  output channels.
- ic  in  I_W  input channels.
- batch  in  B_W  batch count.
- padding_x, padding_y  in  X_W/Y_W  zero padding.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  beat present.
- wei_read_en  out  1  equals out_valid.
- act_read_en  out  1  equals out_valid & ~act_pad.
- wei_read_addr  out  WEI_AW  weight row.
- act_read_addr  out  ACT_AW  activation row.
- act_pad  out  1  beat falls in the padding region; zero-fill the activation.
- pe_valid  out  PES  replicated out_valid.
- first_acc  out  1  first contribution to this output pixel: ii==0, kky==0, kkx==0.
- last_acc  out  1  final contribution to this output pixel.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse at run end.
- cfg_err  out  1  sticky until next start; stride illegal.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-run aborts immediately; done is not pulsed.

State machine:
- IDLE: on start, register the config and go to SETUP.
- SETUP: 1 cycle. Compute ox = ((x + 2*padding_x - fkx) >> log2(stride)) + 1. Compute oy the same way using y, padding_y, fky.
  - Illegal stride: set cfg_err, go to FIN.
  - Any of batch, nc, ic, fkx, fky zero: go to FIN.
  - x + 2*padding_x < fkx, or the y equivalent: go to FIN.
  - Otherwise go to RUN.
- RUN: out_valid = 1. Beat fields derive combinationally from the counter registers.
  - On out_valid & out_ready, advance the counters.
  - While out_ready = 0, all outputs hold stable.
  - Leave RUN on acceptance of the last beat, then go to FIN.
- FIN: assert done for 1 cycle, return to IDLE. busy is low in IDLE only.

Loop order, outer to inner: bb, nn (step LANES), ii (step LANES), kky, kkx, xx, yy. yy is innermost. A counter wraps to 0 when count + step >= bound and carries to the next-outer counter.

Beat count: batch * ceil(nc/LANES) * ceil(ic/LANES) * fky * fkx * ox * oy.

Addressing (n4 = nn/LANES, i4 = ii/LANES, ic4 = ceil(ic/LANES)):
- wei_read_addr = ((n4*ic4 + i4)*fky + kky)*fkx + kkx.
- ix = xx*stride + kkx - padding_x; iy = yy*stride + kky - padding_y; both signed, X_W+2 / Y_W+2 bits.
- act_pad = (ix < 0) | (ix >= x) | (iy < 0) | (iy >= y). When act_pad = 1, act_read_addr = 0.
- Otherwise act_read_addr = ((bb*ic4 + i4)*x + ix)*y + iy.
- All addresses are truncated to the address width; overflow is a configuration error the user avoids and is not checked.

Accumulation markers:
- last_acc = (ii + LANES >= ic) & (kky == fky-1) & (kkx == fkx-1).

start while busy: ignored.

Decomposition:
- Shared package conv_pkg: stride encoding, state enum {IDLE, SETUP, RUN, FIN}, LANES, default width constants.
- One sub-module, conv_loop_counter: a parameterised wrap counter with step/bound/carry-in/carry-out, instantiated 7 times.
- Address arithmetic stays in the top.

Test Plan:
- Baseline: x=y=8, fkx=fky=2, ic=nc=8, batch=1, stride=1, no padding, out_ready=1.
  - 784 beats, then done.
  - Beat 0: wei 0, act 0, first_acc=1.
  - Beat 1: act 1.
  - Beat 49: wei 1, act 8.
  - Last beat: wei 15, act 127, last_acc=1.
- Backpressure: baseline config with out_ready toggling 1010… → same 784-beat sequence; outputs stable during ready=0; done after 1568±1 RUN cycles.
- Padding: x=y=4, fkx=fky=3, padding 1, ic=nc=4 → ox=oy=4, 144 beats.
  - Beat 0 has act_pad=1, act_read_en=0, act_read_addr=0.
  - Beat with kkx=kky=1, xx=yy=0: act_pad=0, act_addr 0.
- Stride 2: x=y=8, fkx=fky=2, ic=nc=4 → ox=oy=4, 64 beats. Beat 1: iy=2, act 2. Stride 3 → cfg_err=1, done, no beats.
- Degenerate: ic=0 → done 2 cycles after start, out_valid never high.
- Reset mid-run: rst at beat 100 → next cycle all outputs 0, no done. A new start replays from beat 0.
